// File: rtl/axi_mem_slv.sv
// AXI3 subordinate backed by a 64-bit word array: one outstanding write and one
// outstanding read, INCR/FIXED bursts, byte-strobed writes, fixed read latency.
module axi_mem_slv #(
    parameter int unsigned ID_WIDTH       = 6,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned B_BURST_LENGTH = 4,
    parameter int unsigned MEM_AW         = 10,
    parameter int unsigned RD_LAT         = 2
) (
    input  logic                      aclk,
    input  logic                      aresetn,

    input  logic [ID_WIDTH-1:0]       s_axi_awid,
    input  logic [31:0]               s_axi_awaddr,
    input  logic [B_BURST_LENGTH-1:0] s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic [1:0]                s_axi_awlock,
    input  logic [3:0]                s_axi_awcache,
    input  logic [2:0]                s_axi_awprot,
    input  logic [3:0]                s_axi_awqos,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,

    input  logic [ID_WIDTH-1:0]       s_axi_wid,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,

    output logic [ID_WIDTH-1:0]       s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,

    input  logic [ID_WIDTH-1:0]       s_axi_arid,
    input  logic [31:0]               s_axi_araddr,
    input  logic [B_BURST_LENGTH-1:0] s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic [1:0]                s_axi_arlock,
    input  logic [3:0]                s_axi_arcache,
    input  logic [2:0]                s_axi_arprot,
    input  logic [3:0]                s_axi_arqos,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,

    output logic [ID_WIDTH-1:0]       s_axi_rid,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned DEPTH  = 2 ** MEM_AW;
    localparam int unsigned LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Sideband and sub-word address fields carry no meaning for this memory.
    logic unused_ok;
    assign unused_ok = ^{s_axi_awaddr[2:0], s_axi_awaddr[31:MEM_AW+3], s_axi_awsize,
                         s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_wid,
                         s_axi_araddr[2:0], s_axi_araddr[31:MEM_AW+3], s_axi_arsize,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

    // ------------------------------------------------------------------ write
    w_state_t                  w_state;
    w_state_t                  w_next;
    logic [MEM_AW-1:0]         w_idx;
    logic [B_BURST_LENGTH-1:0] w_len;
    logic [B_BURST_LENGTH-1:0] w_cnt;
    logic                      w_fixed;
    logic                      w_over;
    logic                      awready_d;
    logic                      wready_d;
    logic                      bvalid_d;
    logic [1:0]                bresp_d;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic mem_we;

    assign aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_hs   = s_axi_wvalid & s_axi_wready;
    assign b_hs   = s_axi_bvalid & s_axi_bready;
    assign mem_we = w_hs & ~w_over;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && s_axi_wlast) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Handshake flags follow the next state so they are valid straight out of a flop.
    always_comb begin
        awready_d = (w_next == W_IDLE);
        wready_d  = (w_next == W_DATA);
        bvalid_d  = (w_next == W_RESP);
        bresp_d   = s_axi_bresp;
        if (w_hs && s_axi_wlast) begin
            bresp_d = (!w_over && (w_cnt == w_len)) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
        end else begin
            s_axi_awready <= awready_d;
            s_axi_wready  <= wready_d;
            s_axi_bvalid  <= bvalid_d;
            s_axi_bresp   <= bresp_d;
        end
    end

    // Burst tracking; beats past awlen set w_over and are swallowed unwritten.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axi_bid <= '0;
            w_idx     <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_fixed   <= 1'b0;
            w_over    <= 1'b0;
        end else if (aw_hs) begin
            s_axi_bid <= s_axi_awid;
            w_idx     <= s_axi_awaddr[3 +: MEM_AW];
            w_len     <= s_axi_awlen;
            w_cnt     <= '0;
            w_fixed   <= (s_axi_awburst == BURST_FIXED);
            w_over    <= 1'b0;
        end else if (mem_we) begin
            if (!s_axi_wlast && (w_cnt == w_len)) begin
                w_over <= 1'b1;
            end else begin
                w_cnt <= w_cnt + B_BURST_LENGTH'(1);
            end
            if (!w_fixed) begin
                w_idx <= w_idx + MEM_AW'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------- read
    r_state_t                  r_state;
    r_state_t                  r_next;
    logic [MEM_AW-1:0]         r_idx;
    logic [MEM_AW-1:0]         r_idx_inc;
    logic [B_BURST_LENGTH-1:0] r_len;
    logic [B_BURST_LENGTH-1:0] r_beat;
    logic                      r_fixed;
    logic [LAT_W-1:0]          r_wait;
    logic                      arready_d;
    logic                      rvalid_d;
    logic                      rlast_d;
    logic [DATA_WIDTH-1:0]     rdata_d;

    logic ar_hs;
    logic r_hs;

    assign ar_hs       = s_axi_arvalid & s_axi_arready;
    assign r_hs        = s_axi_rvalid & s_axi_rready;
    assign r_idx_inc   = r_fixed ? r_idx : (r_idx + MEM_AW'(1));
    assign s_axi_rresp = RESP_OKAY;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_WAIT;
            R_WAIT:  if (r_wait == '0) r_next = R_DATA;
            R_DATA:  if (r_hs && s_axi_rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Data is fetched on entry to R_DATA and on every accepted non-final beat,
    // so it holds steady while the manager stalls.
    always_comb begin
        arready_d = (r_next == R_IDLE);
        rvalid_d  = (r_next == R_DATA);
        rlast_d   = s_axi_rlast;
        rdata_d   = s_axi_rdata;
        if ((r_state == R_WAIT) && (r_next == R_DATA)) begin
            rdata_d = mem[r_idx];
            rlast_d = (r_len == '0);
        end else if (r_hs && !s_axi_rlast) begin
            rdata_d = mem[r_idx_inc];
            rlast_d = ((r_beat + B_BURST_LENGTH'(1)) == r_len);
        end else if (r_hs) begin
            rlast_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rdata   <= '0;
        end else begin
            s_axi_arready <= arready_d;
            s_axi_rvalid  <= rvalid_d;
            s_axi_rlast   <= rlast_d;
            s_axi_rdata   <= rdata_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axi_rid <= '0;
            r_idx     <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_fixed   <= 1'b0;
            r_wait    <= '0;
        end else if (ar_hs) begin
            s_axi_rid <= s_axi_arid;
            r_idx     <= s_axi_araddr[3 +: MEM_AW];
            r_len     <= s_axi_arlen;
            r_beat    <= '0;
            r_fixed   <= (s_axi_arburst == BURST_FIXED);
            r_wait    <= LAT_W'(RD_LAT - 1);
        end else begin
            if ((r_state == R_WAIT) && (r_wait != '0)) begin
                r_wait <= r_wait - LAT_W'(1);
            end
            if (r_hs) begin
                r_beat <= r_beat + B_BURST_LENGTH'(1);
                r_idx  <= r_idx_inc;
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_slv.sv
// Randomized bench for axi_mem_slv: a flat word-array model with byte merging
// and burst address arithmetic predicts every B response and R beat.
module tb_axi_mem_slv;

    localparam int unsigned ID_W   = 6;
    localparam int unsigned MEM_AW = 10;
    localparam int unsigned DEPTH  = 2 ** MEM_AW;
    localparam int          RD_LAT = 2;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [5:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awlen = '0;
    logic [2:0]  awsize = 3'd3;
    logic [1:0]  awburst = 2'b01;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [5:0]  wid = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [5:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [5:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [3:0]  arlen = '0;
    logic [2:0]  arsize = 3'd3;
    logic [1:0]  arburst = 2'b01;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [5:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [63:0] ref_mem [DEPTH];
    bit          written [DEPTH];
    logic [63:0] wq_d [$];
    logic [7:0]  wq_s [$];
    logic [63:0] rd_data [$];
    logic        rd_last [$];
    logic [5:0]  rd_id [$];
    logic [1:0]  rd_resp [$];

    axi_mem_slv #(.ID_WIDTH(ID_W), .DATA_WIDTH(64), .B_BURST_LENGTH(4),
                  .MEM_AW(MEM_AW), .RD_LAT(RD_LAT)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awlock(2'b00),
        .s_axi_awcache(4'h0), .s_axi_awprot(3'h0), .s_axi_awqos(4'h0),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wid(wid), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arlock(2'b00),
        .s_axi_arcache(4'h0), .s_axi_arprot(3'h0), .s_axi_arqos(4'h0),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    // Word touched by beat b of a burst: FIXED stays put, others step and wrap.
    function automatic int model_idx(input logic [31:0] addr, input logic [1:0] burst, input int b);
        int base = int'(addr >> 3) % DEPTH;
        return (burst == 2'b00) ? base : (base + b) % DEPTH;
    endfunction

    // Commits queued beats up to awlen and returns the response the burst earns.
    function automatic logic [1:0] model_write(input logic [31:0] addr, input int len,
                                               input logic [1:0] burst, input int nbeats);
        for (int b = 0; b < nbeats && b <= len; b++) begin
            int idx = model_idx(addr, burst, b);
            for (int k = 0; k < 8; k++) begin
                if (wq_s[b][k]) ref_mem[idx][8*k +: 8] = wq_d[b][8*k +: 8];
            end
            if (wq_s[b] == 8'hFF) written[idx] = 1'b1;
        end
        return (nbeats == len + 1) ? 2'b00 : 2'b10;
    endfunction

    // Starts and ends on a falling edge; beat b carries wlast only on the final beat.
    task automatic axi_write(input logic [5:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input int nbeats, input int bhold,
                             output logic [1:0] resp, output logic [5:0] rbid,
                             output int aw_wait, output bit hold_ok);
        int n;
        resp = 'x; rbid = 'x; hold_ok = 1'b0;
        awid = id; awaddr = addr; awlen = 4'(len); awburst = burst; awvalid = 1'b1;
        aw_wait = 0;
        while (!awready && aw_wait < 100) begin @(negedge aclk); aw_wait++; end
        if (aw_wait >= 100) begin
            checks++; errors++;
            $display("FAIL aw_timeout: awready stayed %b, required 1", awready);
            awvalid = 1'b0;
            return;
        end
        @(negedge aclk);
        awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            wdata = wq_d[b]; wstrb = wq_s[b]; wlast = (b == nbeats - 1); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 100) begin @(negedge aclk); n++; end
            if (n >= 100) begin
                checks++; errors++;
                $display("FAIL w_timeout: wready stayed %b on beat %0d, required 1", wready, b);
                wvalid = 1'b0; wlast = 1'b0;
                return;
            end
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = (bhold == 0);
        n = 0;
        while (!bvalid && n < 100) begin @(negedge aclk); n++; end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL b_timeout: bvalid stayed %b, required 1", bvalid);
            bready = 1'b0;
            return;
        end
        hold_ok = 1'b1;
        for (int h = 0; h < bhold; h++) begin
            if (!bvalid || awready) hold_ok = 1'b0;
            @(negedge aclk);
        end
        bready = 1'b1;
        resp = bresp; rbid = bid;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    // Collects a read burst; with toggle set rready follows 1,0,0,1 while rvalid is high.
    task automatic axi_read(input logic [5:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input bit toggle,
                            output int ar_wait, output int lat, output bit stable_ok);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int pi = 0;
        int cyc = 0;
        bit have_stall = 1'b0;
        logic [63:0] st_d;
        logic st_l;
        logic [5:0] st_i;
        rd_data.delete(); rd_last.delete(); rd_id.delete(); rd_resp.delete();
        stable_ok = 1'b1; lat = -1;
        arid = id; araddr = addr; arlen = 4'(len); arburst = burst; arvalid = 1'b1;
        ar_wait = 0;
        while (!arready && ar_wait < 100) begin @(negedge aclk); ar_wait++; end
        if (ar_wait >= 100) begin
            checks++; errors++;
            $display("FAIL ar_timeout: arready stayed %b, required 1", arready);
            arvalid = 1'b0;
            return;
        end
        @(negedge aclk);
        arvalid = 1'b0;
        rready = 1'b1;
        lat = 0;
        while (!rvalid && lat < 100) begin @(negedge aclk); lat++; end
        while (rd_data.size() < len + 1 && cyc < 500) begin
            rready = toggle ? pat[pi % 4] : 1'b1;
            if (rvalid) begin
                if (have_stall && (rdata !== st_d || rlast !== st_l || rid !== st_i)) stable_ok = 1'b0;
                if (rready) begin
                    rd_data.push_back(rdata); rd_last.push_back(rlast);
                    rd_id.push_back(rid); rd_resp.push_back(rresp);
                    have_stall = 1'b0;
                end else begin
                    have_stall = 1'b1; st_d = rdata; st_l = rlast; st_i = rid;
                end
                pi++;
            end else if (have_stall) begin
                stable_ok = 1'b0;
            end
            @(negedge aclk);
            cyc++;
        end
        rready = 1'b0;
        if (cyc >= 500) begin
            checks++; errors++;
            $display("FAIL r_timeout: got %0d beats, required %0d", rd_data.size(), len + 1);
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        checks++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_flags: aw/ar/w/b/rv/rl = %b, required 110000",
                     {awready, arready, wready, bvalid, rvalid, rlast});
        end
        checks++;
        if ({bresp, rresp, bid, rid} !== 16'h0 || rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_fields: bresp=%b rresp=%b bid=%h rid=%h rdata=%h, required all zero",
                     bresp, rresp, bid, rid, rdata);
        end
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_basic_burst();
        logic [1:0] resp, er;
        logic [5:0] bidv;
        logic [63:0] exp_d [4];
        int aw_wait, ar_wait, lat;
        bit hold_ok, stable_ok;
        logic [5:0] id = 6'($urandom_range(0, 63));
        logic [5:0] id2 = 6'($urandom_range(0, 63));
        exp_d[0] = 64'h1111_1111_1111_1111; exp_d[1] = 64'h2222_2222_2222_2222;
        exp_d[2] = 64'h3333_3333_3333_3333; exp_d[3] = 64'h4444_4444_4444_4444;
        wq_d.delete(); wq_s.delete();
        for (int b = 0; b < 4; b++) begin wq_d.push_back(exp_d[b]); wq_s.push_back(8'hFF); end
        er = model_write(32'h100, 3, 2'b01, 4);
        axi_write(id, 32'h100, 3, 2'b01, 4, 0, resp, bidv, aw_wait, hold_ok);
        checks++;
        if (resp !== er) begin errors++; $display("FAIL basic_bresp: got %b, required %b", resp, er); end
        checks++;
        if (bidv !== id) begin errors++; $display("FAIL basic_bid: got %h, required %h", bidv, id); end
        axi_read(id2, 32'h100, 3, 2'b01, 1'b0, ar_wait, lat, stable_ok);
        checks++;
        if (lat !== RD_LAT) begin errors++; $display("FAIL basic_latency: got %0d, required %0d", lat, RD_LAT); end
        checks++;
        if (rd_data.size() != 4) begin errors++; $display("FAIL basic_count: got %0d, required 4", rd_data.size()); end
        for (int b = 0; b < rd_data.size() && b < 4; b++) begin
            checks++;
            if (rd_data[b] !== exp_d[b] || rd_last[b] !== 1'(b == 3) || rd_id[b] !== id2 || rd_resp[b] !== 2'b00) begin
                errors++;
                $display("FAIL basic_beat%0d: data=%h last=%b id=%h resp=%b, required %h %b %h 00",
                         b, rd_data[b], rd_last[b], rd_id[b], rd_resp[b], exp_d[b], 1'(b == 3), id2);
            end
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp, er;
        logic [5:0] bidv;
        int aw_wait, ar_wait, lat;
        bit hold_ok, stable_ok;
        wq_d.delete(); wq_s.delete();
        wq_d.push_back(64'hFFFF_FFFF_FFFF_FFFF); wq_s.push_back(8'hFF);
        er = model_write(32'h200, 0, 2'b01, 1);
        axi_write(6'h05, 32'h200, 0, 2'b01, 1, 0, resp, bidv, aw_wait, hold_ok);
        wq_d.delete(); wq_s.delete();
        wq_d.push_back(64'h0); wq_s.push_back(8'h0F);
        er = model_write(32'h200, 0, 2'b01, 1);
        axi_write(6'h06, 32'h200, 0, 2'b01, 1, 0, resp, bidv, aw_wait, hold_ok);
        checks++;
        if (resp !== er) begin errors++; $display("FAIL strobe_bresp: got %b, required %b", resp, er); end
        axi_read(6'h07, 32'h200, 0, 2'b01, 1'b0, ar_wait, lat, stable_ok);
        checks++;
        if (rd_data.size() != 1 || rd_data[0] !== 64'hFFFF_FFFF_0000_0000) begin
            errors++;
            $display("FAIL strobe_data: got %h, required ffffffff00000000", rd_data.size() ? rd_data[0] : 64'hx);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp, er;
        logic [5:0] bidv;
        int aw_wait, ar_wait, lat;
        bit hold_ok, stable_ok;
        wq_d.delete(); wq_s.delete();
        for (int b = 0; b < 16; b++) begin wq_d.push_back({$urandom, $urandom}); wq_s.push_back(8'hFF); end
        er = model_write(32'h400, 15, 2'b01, 16);
        axi_write(6'h2A, 32'h400, 15, 2'b01, 16, 5, resp, bidv, aw_wait, hold_ok);
        checks++;
        if (!hold_ok) begin errors++; $display("FAIL bp_bhold: bvalid dropped or awready rose during hold, hold_ok=%b required 1", hold_ok); end
        checks++;
        if (resp !== er) begin errors++; $display("FAIL bp_bresp: got %b, required %b", resp, er); end
        axi_read(6'h2B, 32'h400, 15, 2'b01, 1'b1, ar_wait, lat, stable_ok);
        checks++;
        if (!stable_ok) begin errors++; $display("FAIL bp_stable: outputs changed while stalled, stable=%b required 1", stable_ok); end
        checks++;
        if (rd_data.size() != 16) begin errors++; $display("FAIL bp_count: got %0d, required 16", rd_data.size()); end
        for (int b = 0; b < rd_data.size() && b < 16; b++) begin
            int idx = model_idx(32'h400, 2'b01, b);
            checks++;
            if (rd_data[b] !== ref_mem[idx] || rd_last[b] !== 1'(b == 15)) begin
                errors++;
                $display("FAIL bp_beat%0d: data=%h last=%b, required %h %b", b, rd_data[b], rd_last[b], ref_mem[idx], 1'(b == 15));
            end
        end
    endtask

    task automatic test_wrap_fixed();
        logic [1:0] resp, er;
        logic [5:0] bidv;
        logic [63:0] exp_d [4];
        int aw_wait, ar_wait, lat;
        bit hold_ok, stable_ok;
        logic [31:0] top = 32'((DEPTH - 1) * 8);
        wq_d.delete(); wq_s.delete();
        wq_d.push_back(64'hAAAA_0000_0000_AAAA); wq_s.push_back(8'hFF);
        wq_d.push_back(64'hBBBB_0000_0000_BBBB); wq_s.push_back(8'hFF);
        er = model_write(top, 1, 2'b01, 2);
        axi_write(6'h11, top, 1, 2'b01, 2, 0, resp, bidv, aw_wait, hold_ok);
        axi_read(6'h12, 32'h0, 0, 2'b01, 1'b0, ar_wait, lat, stable_ok);
        checks++;
        if (rd_data.size() != 1 || rd_data[0] !== 64'hBBBB_0000_0000_BBBB) begin
            errors++; $display("FAIL wrap_index0: got %h, required bbbb00000000bbbb", rd_data.size() ? rd_data[0] : 64'hx);
        end
        axi_read(6'h13, top, 1, 2'b01, 1'b0, ar_wait, lat, stable_ok);
        checks++;
        if (rd_data.size() != 2 || rd_data[0] !== 64'hAAAA_0000_0000_AAAA || rd_data[1] !== 64'hBBBB_0000_0000_BBBB) begin
            errors++; $display("FAIL wrap_read: got %0d beats, first %h", rd_data.size(), rd_data.size() ? rd_data[0] : 64'hx);
        end
        // Known background, then a FIXED burst that must only touch the first word.
        wq_d.delete(); wq_s.delete();
        for (int b = 0; b < 4; b++) begin wq_d.push_back(64'hC0C0_0000_0000_0000 + 64'(b)); wq_s.push_back(8'hFF); end
        er = model_write(32'h300, 3, 2'b01, 4);
        axi_write(6'h14, 32'h300, 3, 2'b01, 4, 0, resp, bidv, aw_wait, hold_ok);
        wq_d.delete(); wq_s.delete();
        for (int b = 0; b < 4; b++) begin wq_d.push_back(64'hF1F0_0000_0000_0000 + 64'(b)); wq_s.push_back(8'hFF); end
        er = model_write(32'h300, 3, 2'b00, 4);
        axi_write(6'h15, 32'h300, 3, 2'b00, 4, 0, resp, bidv, aw_wait, hold_ok);
        checks++;
        if (resp !== er) begin errors++; $display("FAIL fixed_bresp: got %b, required %b", resp, er); end
        exp_d[0] = 64'hF1F0_0000_0000_0003; exp_d[1] = 64'hC0C0_0000_0000_0001;
        exp_d[2] = 64'hC0C0_0000_0000_0002; exp_d[3] = 64'hC0C0_0000_0000_0003;
        axi_read(6'h16, 32'h300, 3, 2'b01, 1'b0, ar_wait, lat, stable_ok);
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (b >= rd_data.size() || rd_data[b] !== exp_d[b]) begin
                errors++; $display("FAIL fixed_word%0d: got %h, required %h", b, b < rd_data.size() ? rd_data[b] : 64'hx, exp_d[b]);
            end
        end
        // FIXED read returns the same word on every beat.
        axi_read(6'h17, 32'h300, 2, 2'b00, 1'b0, ar_wait, lat, stable_ok);
        for (int b = 0; b < rd_data.size(); b++) begin
            checks++;
            if (rd_data[b] !== exp_d[0]) begin errors++; $display("FAIL fixed_read%0d: got %h, required %h", b, rd_data[b], exp_d[0]); end
        end
    endtask

    task automatic test_proto_error();
        logic [1:0] resp, er;
        logic [5:0] bidv;
        int aw_wait, ar_wait, lat;
        bit hold_ok, stable_ok;
        wq_d.delete(); wq_s.delete();
        for (int b = 0; b < 4; b++) begin wq_d.push_back(64'h5A5A_0000_0000_0000 + 64'(b)); wq_s.push_back(8'hFF); end
        er = model_write(32'h500, 3, 2'b01, 4);
        axi_write(6'h21, 32'h500, 3, 2'b01, 4, 0, resp, bidv, aw_wait, hold_ok);
        wq_d.delete(); wq_s.delete();
        for (int b = 0; b < 2; b++) begin wq_d.push_back(64'hE0E0_0000_0000_0000 + 64'(b)); wq_s.push_back(8'hFF); end
        er = model_write(32'h500, 3, 2'b01, 2);
        axi_write(6'h22, 32'h500, 3, 2'b01, 2, 0, resp, bidv, aw_wait, hold_ok);
        checks++;
        if (resp !== 2'b10 || resp !== er) begin errors++; $display("FAIL early_wlast_bresp: got %b, required 10", resp); end
        wq_d.delete(); wq_s.delete();
        for (int b = 0; b < 4; b++) begin wq_d.push_back(64'hD0D0_0000_0000_0000 + 64'(b)); wq_s.push_back(8'hFF); end
        er = model_write(32'h500, 1, 2'b01, 4);
        axi_write(6'h23, 32'h500, 1, 2'b01, 4, 0, resp, bidv, aw_wait, hold_ok);
        checks++;
        if (aw_wait != 0) begin errors++; $display("FAIL err_idle: waited %0d cycles for awready, required 0", aw_wait); end
        checks++;
        if (resp !== 2'b10 || resp !== er) begin errors++; $display("FAIL excess_bresp: got %b, required 10", resp); end
        axi_read(6'h24, 32'h500, 3, 2'b01, 1'b0, ar_wait, lat, stable_ok);
        for (int b = 0; b < rd_data.size() && b < 4; b++) begin
            int idx = model_idx(32'h500, 2'b01, b);
            checks++;
            if (rd_data[b] !== ref_mem[idx]) begin errors++; $display("FAIL err_word%0d: got %h, required %h", b, rd_data[b], ref_mem[idx]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp, er;
        logic [5:0] bidv;
        int aw_wait, ar_wait, lat;
        bit hold_ok, stable_ok, held;
        wvalid = 1'b1; wdata = 64'hDEAD_BEEF_DEAD_BEEF; wstrb = 8'hFF; wlast = 1'b1;
        held = 1'b1;
        repeat (3) begin if (wready) held = 1'b0; @(negedge aclk); end
        checks++;
        if (!held) begin errors++; $display("FAIL w_before_aw: wready seen 1 in idle, required 0"); end
        wq_d.delete(); wq_s.delete();
        wq_d.push_back(64'h0123_4567_89AB_CDEF); wq_s.push_back(8'hFF);
        er = model_write(32'h600, 0, 2'b01, 1);
        axi_write(6'h31, 32'h600, 0, 2'b01, 1, 0, resp, bidv, aw_wait, hold_ok);
        wq_d.delete(); wq_s.delete();
        wq_d.push_back(64'hFEDC_BA98_7654_3210); wq_s.push_back(8'hFF);
        er = model_write(32'h608, 0, 2'b01, 1);
        axi_write(6'h32, 32'h608, 0, 2'b01, 1, 0, resp, bidv, aw_wait, hold_ok);
        checks++;
        if (aw_wait != 0) begin errors++; $display("FAIL b2b_aw: waited %0d cycles, required 0", aw_wait); end
        axi_read(6'h33, 32'h600, 0, 2'b01, 1'b0, ar_wait, lat, stable_ok);
        axi_read(6'h34, 32'h608, 0, 2'b01, 1'b0, ar_wait, lat, stable_ok);
        checks++;
        if (ar_wait != 0 || rd_data.size() != 1 || rd_data[0] !== 64'hFEDC_BA98_7654_3210) begin
            errors++; $display("FAIL b2b_ar: ar_wait=%0d beats=%0d, required 0 and fedcba9876543210", ar_wait, rd_data.size());
        end
    endtask

    task automatic test_reset_mid_read();
        logic [1:0] resp, er;
        logic [5:0] bidv;
        int aw_wait, ar_wait, lat, n, cnt;
        bit hold_ok, stable_ok, quiet;
        wq_d.delete(); wq_s.delete();
        for (int b = 0; b < 8; b++) begin wq_d.push_back({$urandom, $urandom}); wq_s.push_back(8'hFF); end
        er = model_write(32'h700, 7, 2'b01, 8);
        axi_write(6'h3A, 32'h700, 7, 2'b01, 8, 0, resp, bidv, aw_wait, hold_ok);
        arid = 6'h3B; araddr = 32'h700; arlen = 4'd7; arburst = 2'b01; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin @(negedge aclk); n++; end
        @(negedge aclk);
        arvalid = 1'b0; rready = 1'b1;
        cnt = 0; n = 0;
        while (cnt < 2 && n < 100) begin if (rvalid) cnt++; @(negedge aclk); n++; end
        checks++;
        if (!rvalid) begin errors++; $display("FAIL rst_pre: rvalid=%b on beat 2, required 1", rvalid); end
        aresetn = 1'b0; rready = 1'b0;
        #1;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1 || rlast !== 1'b0) begin
            errors++; $display("FAIL rst_mid: rvalid=%b arready=%b rlast=%b, required 0 1 0", rvalid, arready, rlast);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        quiet = 1'b1;
        repeat (4) begin @(negedge aclk); if (rvalid || bvalid) quiet = 1'b0; end
        checks++;
        if (!quiet) begin errors++; $display("FAIL rst_quiet: completion seen after reset, required none"); end
        axi_read(6'h3C, 32'h700, 7, 2'b01, 1'b0, ar_wait, lat, stable_ok);
        checks++;
        if (rd_data.size() != 8 || lat != RD_LAT) begin errors++; $display("FAIL rst_after_count: beats=%0d lat=%0d, required 8 %0d", rd_data.size(), lat, RD_LAT); end
        for (int b = 0; b < rd_data.size(); b++) begin
            int idx = model_idx(32'h700, 2'b01, b);
            checks++;
            if (rd_data[b] !== ref_mem[idx]) begin errors++; $display("FAIL rst_after_beat%0d: got %h, required %h", b, rd_data[b], ref_mem[idx]); end
        end
    endtask

    task automatic test_random();
        logic [1:0] resp, er, burst;
        logic [5:0] bidv, id;
        logic [31:0] addr;
        int aw_wait, ar_wait, lat, len, nb;
        bit hold_ok, stable_ok;
        for (int it = 0; it < 24; it++) begin
            addr = ($urandom_range(0, 3) == 0) ? 32'(($urandom_range(DEPTH - 8, DEPTH - 1)) * 8 + $urandom_range(0, 7))
                                               : 32'($urandom_range(0, 48) * 8 + $urandom_range(0, 7));
            len = $urandom_range(0, 15);
            burst = 2'($urandom_range(0, 2));
            nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 16) : len + 1;
            id = 6'($urandom_range(0, 63));
            wq_d.delete(); wq_s.delete();
            for (int b = 0; b < nb; b++) begin
                wq_d.push_back({$urandom, $urandom});
                wq_s.push_back(($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom));
            end
            er = model_write(addr, len, burst, nb);
            axi_write(id, addr, len, burst, nb, $urandom_range(0, 2), resp, bidv, aw_wait, hold_ok);
            checks++;
            if (resp !== er || bidv !== id) begin
                errors++; $display("FAIL rand_b%0d: resp=%b id=%h, required %b %h", it, resp, bidv, er, id);
            end
            len = $urandom_range(0, 15);
            burst = 2'($urandom_range(0, 2));
            id = 6'($urandom_range(0, 63));
            axi_read(id, addr, len, burst, 1'($urandom_range(0, 1)), ar_wait, lat, stable_ok);
            checks++;
            if (rd_data.size() != len + 1 || !stable_ok) begin
                errors++; $display("FAIL rand_r%0d: beats=%0d stable=%b, required %0d 1", it, rd_data.size(), stable_ok, len + 1);
            end
            for (int b = 0; b < rd_data.size(); b++) begin
                int idx = model_idx(addr, burst, b);
                checks++;
                if ((written[idx] && rd_data[b] !== ref_mem[idx]) || rd_last[b] !== 1'(b == len) || rd_id[b] !== id) begin
                    errors++;
                    $display("FAIL rand_r%0d_beat%0d: data=%h last=%b id=%h, required %h %b %h",
                             it, b, rd_data[b], rd_last[b], rd_id[b], ref_mem[idx], 1'(b == len), id);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_strobe();
        test_backpressure();
        test_wrap_fixed();
        test_proto_error();
        test_back_to_back();
        test_reset_mid_read();
        do_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_mem_slv.md
# axi_mem_slv

AXI3 full-protocol subordinate backed by an on-chip word array; it is the responder end of the DDR master port that the TPU top exposes. It accepts INCR/FIXED bursts on the write and read channels, commits byte-strobed 64-bit writes and returns read bursts after a programmable latency. It stands in for the PS DDR port in block-level and top-level benches, and as a small on-fabric scratch memory.

## Interface
- ID_WIDTH, 6, width of all ID fields
- DATA_WIDTH, 64, data bus width; fixed 64 (8-byte beats)
- B_BURST_LENGTH, 4, width of awlen/arlen (AXI3 max 16 beats)
- MEM_AW, 10, word-address bits; array depth 2^MEM_AW words
- RD_LAT, 2, cycles from AR handshake to first rvalid (>=1)

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous, active-low reset
- s_axi_awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_WIDTH/32/B_BURST_LENGTH/3/2/1  write address
- s_axi_awready  out  1
- s_axi_wid/wdata/wstrb/wlast/wvalid  in  ID_WIDTH/64/8/1/1  write data
- s_axi_wready  out  1
- s_axi_bid/bresp/bvalid  out  ID_WIDTH/2/1; s_axi_bready  in  1
- s_axi_arid/araddr/arlen/arsize/arburst/arvalid  in  ID_WIDTH/32/B_BURST_LENGTH/3/2/1
- s_axi_arready  out  1
- s_axi_rid/rdata/rresp/rlast/rvalid  out  ID_WIDTH/64/2/1/1; s_axi_rready  in  1
- awlock/awcache/awprot/awqos and ar equivalents: accepted, ignored

## Operation
- Independent write and read FSMs; one outstanding transaction per direction.
- Word index = addr[3+:MEM_AW]; addr[2:0] and upper bits ignored (aliasing wraps modulo depth). awsize/arsize ignored; every beat is 8 bytes.
- Burst: awburst/arburst==2'b00 (FIXED) holds index; any other value increments index by 1 per beat, wrapping at 2^MEM_AW-1 -> 0.
- Write FSM: W_IDLE (awready=1) -> on awvalid&awready latch id, index, len, burst; beat counter=0 -> W_DATA (wready=1): each wvalid&wready writes bytes where wstrb[i]=1, counter++ -> on wlast -> W_RESP (bvalid=1, bid=latched awid) -> on bready -> W_IDLE.
- bresp=OKAY (00) if wlast arrived on beat awlen; SLVERR (10) if wlast early or beat count exceeded awlen without wlast (excess beats still accepted, not written).
- Read FSM: R_IDLE (arready=1) -> on handshake latch id, index, len; load wait counter RD_LAT-1 -> R_WAIT counts down -> R_DATA (rvalid=1, rid, rdata=mem[index], rresp=00, rlast=(beat==arlen)) -> each rvalid&rready advances beat/index -> after last beat accepted -> R_IDLE.
- rdata/rlast/rid stable while rvalid&!rready.
- Memory array is not cleared by reset.

## Timing
- Reset values (aresetn=0): awready=1, arready=1, wready=0, bvalid=0, bresp=00, bid=0, rvalid=0, rlast=0, rresp=00, rid=0, rdata=0; both FSMs in IDLE.
- Reset mid-burst: FSMs return to IDLE immediately; beats already written remain committed; no B or R completion issued.
- awready deasserts the cycle after AW handshake; wready asserts that same cycle (first W beat may be accepted one cycle after AW).
- W data presented before AW is held off (wready=0 in W_IDLE).
- bvalid rises the cycle after the wlast beat; bvalid held until bready.
- First rvalid exactly RD_LAT cycles after the AR handshake edge; back-to-back beats at 1/cycle with rready=1.
- Read of a word written in the same cycle returns the pre-write value; value from the following cycle on.
- Next AW/AR accepted the cycle after the previous transaction completes (B or last R handshake).

## Test plan
- Write burst awaddr=0x100, awlen=3, data 0x11..,0x22..,0x33..,0x44.., wstrb=FF -> bresp=00, bid=awid; read same burst arlen=3 -> four beats in order, rlast on beat 3, first rvalid RD_LAT cycles after AR.
- Strobe: write 0xFFFF_FFFF_FFFF_FFFF then 0x0 with wstrb=0x0F to one word -> read returns 0xFFFF_FFFF_0000_0000.
- Backpressure: read arlen=15 with rready toggling 1,0,0,1 -> 16 beats, no loss/duplicate, rdata stable while stalled; bready held low 5 cycles -> bvalid stays 1, no new AW accepted.
- Wrap/FIXED: INCR write at last word index, awlen=1 -> second beat lands at index 0; FIXED awlen=3 -> only final beat's data remains at that index.
- Protocol error: awlen=3 with wlast on beat 1 -> bresp=10 (SLVERR), FSM returns to W_IDLE.
- Reset asserted during R_DATA beat 2 of 8 -> rvalid=0 immediately, arready=1; subsequent read completes normally.
